// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types, widths and shift/saturate helper for the psum accumulator
package cnn_pkg;

    localparam int CNN_PSUM_W = 16;
    localparam int CNN_ACC_W  = 32;
    localparam int CNN_DATA_W = 16;

    typedef logic signed [CNN_PSUM_W-1:0] psum_t;
    typedef logic signed [CNN_ACC_W-1:0]  acc_t;
    typedef logic signed [CNN_DATA_W-1:0] data_t;

    typedef enum logic [1:0] {IDLE, ACC, DONE} cnn_acc_state_e;

    // Arithmetic shift rounds toward -inf; the result is then clamped to the data range.
    function automatic data_t sat_shift(input acc_t a, input int unsigned frac);
        acc_t s;
        acc_t hi;
        acc_t lo;
        hi = acc_t'((64'sd1 <<< (CNN_DATA_W - 1)) - 64'sd1);
        lo = -hi - acc_t'(1);
        s  = a >>> frac;
        if (s > hi) begin
            return hi[CNN_DATA_W-1:0];
        end else if (s < lo) begin
            return lo[CNN_DATA_W-1:0];
        end
        return s[CNN_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/cnn_lane_accum.sv
// rtl/cnn_lane_accum.sv - one output-channel lane: accumulator, shift, saturate, output register
// Optional rectification of negative results under CNN_PSUM_RELU_EN.
module cnn_lane_accum
    import cnn_pkg::*;
#(
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 32,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              clear_i,
    input  logic              beat_en_i,
    input  logic              first_i,
    input  logic              load_i,
    input  logic [PSUM_W-1:0] psum_i,
    output logic [DATA_W-1:0] fm_o
);

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  base;
    logic signed [ACC_W-1:0]  ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [DATA_W-1:0] sat;
    logic signed [DATA_W-1:0] res;

    always_comb begin
        base = first_i ? '0 : acc;
        ext  = ACC_W'(signed'(psum_i));
        sum  = base + ext;
    end

    // The final beat's sum is saturated directly so the output lands one cycle after that beat.
    if (ACC_W == CNN_ACC_W && DATA_W == CNN_DATA_W) begin : g_pkg_sat
        assign sat = sat_shift(sum, FRAC_W);
    end else begin : g_generic_sat
        localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
        localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
        logic signed [ACC_W-1:0] shifted;
        always_comb begin
            shifted = sum >>> FRAC_W;
            if (shifted > SAT_MAX) begin
                sat = SAT_MAX[DATA_W-1:0];
            end else if (shifted < SAT_MIN) begin
                sat = SAT_MIN[DATA_W-1:0];
            end else begin
                sat = shifted[DATA_W-1:0];
            end
        end
    end

`ifdef CNN_PSUM_RELU_EN
    assign res = sat[DATA_W-1] ? '0 : sat;
`else
    assign res = sat;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc  <= '0;
            fm_o <= '0;
        end else begin
            if (clear_i) begin
                acc <= '0;
            end else if (beat_en_i) begin
                acc <= sum;
            end
            if (load_i) begin
                fm_o <= res;
            end
        end
    end

endmodule

// File: rtl/cnn_psum_accum.sv
// rtl/cnn_psum_accum.sv - partial-sum accumulator top: layer FSM, beat/pixel counters, output handshake
// Lane ReLU is selected by CNN_PSUM_RELU_EN inside cnn_lane_accum.
module cnn_psum_accum
    import cnn_pkg::*;
#(
    parameter int N_p    = 4,
    parameter int Tn_p   = 2,
    parameter int Tm_p   = 2,
    parameter int K_p    = 2,
    parameter int R_p    = 16,
    parameter int C_p    = 16,
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 32,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    localparam int ROW_W = (R_p > 1) ? $clog2(R_p) : 1,
    localparam int COL_W = (C_p > 1) ? $clog2(C_p) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    input  logic [Tm_p*PSUM_W-1:0] psum_i,
    input  logic                   psum_valid_i,
    output logic                   psum_ready_o,
    output logic [Tm_p*DATA_W-1:0] fm_o,
    output logic                   fm_valid_o,
    input  logic                   fm_ready_i,
    output logic [ROW_W-1:0]       row_o,
    output logic [COL_W-1:0]       col_o,
    output logic                   busy_o,
    output logic                   done_o
);

    localparam int BEATS  = K_p * K_p * N_p / Tn_p;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(R_p - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(C_p - 1);

    if (N_p % Tn_p != 0) begin : g_bad_tile
        $error("N_p must be a multiple of Tn_p");
    end
    if (PSUM_W + $clog2(BEATS) > ACC_W) begin : g_bad_acc
        $error("ACC_W too narrow for PSUM_W + clog2(BEATS)");
    end

    cnn_acc_state_e   state;
    logic [BEAT_W-1:0] beat;
    logic [ROW_W-1:0]  pix_row;
    logic [COL_W-1:0]  pix_col;

    logic last_beat;
    logic beat_fire;
    logic out_fire;
    logic start_go;
    logic load;
    logic last_out;

    // Only the final beat of a pixel waits on the single-entry output register.
    assign last_beat    = (beat == BEAT_LAST);
    assign psum_ready_o = (state == ACC) && !(last_beat && fm_valid_o && !fm_ready_i);
    assign beat_fire    = psum_valid_i && psum_ready_o;
    assign out_fire     = fm_valid_o && fm_ready_i;
    assign start_go     = start_i && (state != ACC);
    assign load         = beat_fire && last_beat;
    assign last_out     = (row_o == ROW_LAST) && (col_o == COL_LAST);

    for (genvar l = 0; l < Tm_p; l++) begin : g_lane
        cnn_lane_accum #(
            .PSUM_W (PSUM_W),
            .ACC_W  (ACC_W),
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W)
        ) u_lane (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .clear_i   (start_go),
            .beat_en_i (beat_fire),
            .first_i   (beat == '0),
            .load_i    (load),
            .psum_i    (psum_i[l*PSUM_W +: PSUM_W]),
            .fm_o      (fm_o[l*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= IDLE;
            beat       <= '0;
            pix_row    <= '0;
            pix_col    <= '0;
            row_o      <= '0;
            col_o      <= '0;
            fm_valid_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state   <= ACC;
                        beat    <= '0;
                        pix_row <= '0;
                        pix_col <= '0;
                        busy_o  <= 1'b1;
                        done_o  <= 1'b0;
                    end
                end
                ACC: begin
                    if (beat_fire) begin
                        beat <= last_beat ? '0 : beat + 1'b1;
                    end
                    if (load) begin
                        fm_valid_o <= 1'b1;
                        row_o      <= pix_row;
                        col_o      <= pix_col;
                        if (pix_col == COL_LAST) begin
                            pix_col <= '0;
                            pix_row <= (pix_row == ROW_LAST) ? '0 : pix_row + 1'b1;
                        end else begin
                            pix_col <= pix_col + 1'b1;
                        end
                    end else if (out_fire) begin
                        fm_valid_o <= 1'b0;
                    end
                    if (out_fire && last_out) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
